dff_pipe_sync_rst_en: RTL
=========================

# dff_pipe_sync_rst_en

Parametrised multi-stage register pipeline with per-stage valid tracking, valid/ready flow control, bubble collapsing, global enable and synchronous flush. It generalises the single enabled D flip-flop into a DEPTH-deep, WIDTH-wide elastic pipeline. Use it to add register stages to long datapaths where the consumer can stall.

## Interface
- WIDTH, default 4: data width in bits, WIDTH ≥ 1.
- DEPTH, default 3: number of register stages, DEPTH ≥ 1.
- CNT_W, derived as $clog2(DEPTH+1): width of the `count` output.

- clk  input  1  rising-edge clock; the only clock.
- sync_rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- enabler  input  1  global enable; when low the pipeline is frozen.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  data register of the last stage (stage DEPTH-1).
- count  output  CNT_W  number of valid stages, 0..DEPTH.

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side): `v[i]` (1 bit) and `d[i]` (WIDTH bits).
- Priority per cycle: sync_rst > flush > enabler > normal flow.
- sync_rst = 1: all v = 0 and all d = 0 at the next edge. All outputs read 0 in the following cycle.
- flush = 1 (no reset): all v = 0 at the next edge. d holds its value. The flush cycle has no transfer on either side. flush acts even when enabler = 0.
- enabler = 0 (no reset, no flush): no register changes.
- Advance rule, with en_eff = enabler && !flush:
  - adv[DEPTH-1] = v[DEPTH-1] && out_ready.
  - Stage i can load when load_ok[i] = !v[i] || adv[i].
  - adv[i] for i < DEPTH-1 = v[i] && load_ok[i+1].
- Input handshake: in_ready = en_eff && load_ok[0]. Input transfer = in_valid && in_ready.
- Output handshake: out_valid = en_eff && v[DEPTH-1]. Output transfer = out_valid && out_ready.
- Stage update when en_eff = 1:
  - Stage 0 loads in_data when there is an input transfer.
  - Stage i > 0 loads d[i-1] when adv[i-1] is true.
  - v[i] next = loaded || (v[i] && !adv[i]).
  - d is written only on a load.
- Bubble collapsing: a valid stage moves forward whenever the next stage is empty or advancing, even if the output is stalled. Holes close up.
- count = population count of v, registered alongside v. Next count = count + input transfer − output transfer. flush or reset sets it to 0.
- Data order is strictly preserved. No item is dropped or duplicated.
- DEPTH = 1: reduces to a single register with in_ready = en_eff && (!v[0] || out_ready).

## Timing
- Reset values: in_ready = 0 during the reset cycle, 1 after it (when enabler = 1). out_valid = 0, out_data = 0, count = 0.
- Latency: an item accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles from in_valid to out_valid, when there are no stalls.
- Throughput: 1 item per cycle while out_ready = 1.
- in_ready is combinational from out_ready, enabler and flush through the load_ok chain. out_valid is combinational from enabler and flush. No other comb paths.
- Full (count = DEPTH) with out_ready = 0: in_ready = 0.
- Full with out_ready = 1: in_ready = 1. Simultaneous in/out transfer; count stays DEPTH.
- Empty: out_valid = 0. Input accepted regardless of out_ready.
- Reset or flush mid-stream: in-flight items are discarded. A new item may be accepted on the cycle after reset/flush deasserts.
- Upstream must hold in_data stable while in_valid && !in_ready. Outputs stay stable while out_valid && !out_ready.

## Test plan
- Reset, then DEPTH=3: feed 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready = 1 -> out_valid rises 3 cycles after the first accept; outputs 0x1..0x4 back-to-back; count peaks at 3.
- Hold out_ready = 0 and stream 5 items -> exactly 3 accepted, in_ready = 0, count = 3. Release out_ready -> items emerge in order with no loss.
- Create a bubble: accept 0xA, idle one cycle, accept 0xB, out_ready = 0 -> both items collapse into stages 2 and 1 and count = 2. Then out_ready = 1 -> 0xA then 0xB on consecutive cycles.
- Assert flush with count = 2 and in_valid = 1 -> in_ready = 0 and out_valid = 0 that cycle; count = 0 next cycle; the flushed input is not captured.
- Drop enabler for 4 cycles mid-stream with out_ready = 1 -> no transfers, state and count frozen; resume with the same order and no duplicates.
- Assert sync_rst while full, then DEPTH=1 build: alternate in_valid/out_ready patterns -> after reset out_data = 0 and count = 0; DEPTH=1 accepts and emits 1 item per cycle when out_ready = 1.

Source files
------------

// File: rtl/dff_pipe_sync_rst_en.sv
// Elastic DEPTH-stage register pipeline with valid/ready flow control,
// bubble collapsing, global enable, synchronous flush and synchronous reset.
module dff_pipe_sync_rst_en #(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             enabler,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    logic             en_eff;
    logic             in_xfer;
    logic             out_xfer;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] load_ok;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;

    assign en_eff    = enabler && !flush && !sync_rst;
    assign in_ready  = en_eff && load_ok[0];
    assign out_valid = en_eff && v[DEPTH-1];
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] d_q;
        logic [WIDTH-1:0] d_src;

        // The recursive load_ok/adv chain is flattened: a stage can load when
        // the output drains or any stage from here downstream is empty.
        assign load_ok[g] = out_ready || !(&v[DEPTH-1:g]);

        if (g == DEPTH - 1) begin : g_last
            assign adv[g] = v[g] && out_ready;
        end else begin : g_mid
            assign adv[g] = v[g] && load_ok[g+1];
        end

        if (g == 0) begin : g_first
            assign load[g] = in_xfer;
            assign d_src   = in_data;
        end else begin : g_next
            assign load[g] = adv[g-1];
            assign d_src   = g_stage[g-1].d_q;
        end

        assign v_nxt[g] = load[g] || (v[g] && !adv[g]);

        always_ff @(posedge clk) begin
            if (sync_rst) begin
                d_q <= '0;
            end else if (en_eff && load[g]) begin
                d_q <= d_src;
            end
        end
    end

    assign out_data = g_stage[DEPTH-1].d_q;

    always_ff @(posedge clk) begin
        if (sync_rst || flush) begin
            v     <= '0;
            count <= '0;
        end else if (enabler) begin
            v     <= v_nxt;
            count <= count + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

endmodule
